// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings,
// default latencies and the controller state type.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'b0000,
    OP_MULT  = 4'b0001,
    OP_MULTU = 4'b0010,
    OP_DIV   = 4'b0011,
    OP_DIVU  = 4'b0100,
    OP_MTHI  = 4'b0101,
    OP_MTLO  = 4'b0110
  } mdu_op_e;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // True for the ops that open a multi-cycle busy window.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // True for the divide ops (they use the longer latency).
  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result for MULT/MULTU/DIV/DIVU, packed as {HI,LO},
// plus a divide-by-zero flag so the controller can leave HI/LO untouched.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [63:0] res,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        mag_a;
  logic [31:0]        mag_b;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic [31:0]        q_s;
  logic [31:0]        r_s;
  logic [31:0]        dvu;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  // Signed division works on magnitudes so 0x80000000 / -1 wraps cleanly;
  // a zero divisor is replaced by 1 to keep the datapath X-free (result unused).
  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};

    mag_a  = a[31] ? (~a + 32'd1) : a;
    mag_b  = b[31] ? (~b + 32'd1) : b;
    if (b == 32'd0) mag_b = 32'd1;
    q_mag  = mag_a / mag_b;
    r_mag  = mag_a % mag_b;
    q_s    = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = a[31] ? (~r_mag + 32'd1) : r_mag;

    dvu    = (b == 32'd0) ? 32'd1 : b;
    q_u    = a / dvu;
    r_u    = a % dvu;

    res = 64'd0;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = {r_s, q_s};
      OP_DIVU:  res = {r_u, q_u};
      default:  res = 64'd0;
    endcase

    div_zero = is_div_op(op) && (b == 32'd0);
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller: sequences a fixed busy window,
// commits pending results to HI/LO, handles MTHI/MTLO, cancel and MFHI/MFLO mux.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MDUIn1,
  input  logic [31:0] MDUIn2,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        Cancel,
  input  logic        MFSel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] ar_res;
  logic        ar_div_zero;

  mdu_arith u_arith (
    .a        (MDUIn1),
    .b        (MDUIn2),
    .op       (MDUOp),
    .res      (ar_res),
    .div_zero (ar_div_zero)
  );

  // Next-state logic: accept ops in IDLE, count down and commit in RUN; cancel wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (Start && !Cancel) begin
          if (is_long_op(MDUOp)) begin
            // A zero divisor pends the current HI/LO, so the commit is a no-op.
            if (ar_div_zero) begin
              phi_d = hi_q;
              plo_d = lo_q;
            end else begin
              phi_d = ar_res[63:32];
              plo_d = ar_res[31:0];
            end
            cnt_d   = is_div_op(MDUOp) ? 4'(DIV_LAT) : 4'(MUL_LAT);
            state_d = RUN;
          end else if (MDUOp == OP_MTHI) begin
            hi_d = MDUIn1;
          end else if (MDUOp == OP_MTLO) begin
            lo_d = MDUIn1;
          end
        end
      end
      RUN: begin
        if (Cancel) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            hi_d    = phi_q;
            lo_d    = plo_q;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy   = (state_q == RUN);
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign MDUOut = MFSel ? lo_q : hi_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed scenarios followed by random ops,
// compared against an arithmetic reference model of HI/LO.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] MDUIn1, MDUIn2;
  logic [3:0]  MDUOp;
  logic        Start, Cancel, MFSel;
  logic        Busy;
  logic [31:0] HI, LO, MDUOut;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_hi, m_lo;

  localparam logic [3:0] T_NONE = 4'd0, T_MULT = 4'd1, T_MULTU = 4'd2, T_DIV = 4'd3,
                         T_DIVU = 4'd4, T_MTHI = 4'd5, T_MTLO = 4'd6;

  mdu_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .MDUIn1 (MDUIn1),
    .MDUIn2 (MDUIn2),
    .MDUOp  (MDUOp),
    .Start  (Start),
    .Cancel (Cancel),
    .MFSel  (MFSel),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO),
    .MDUOut (MDUOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference: what HI/LO become once an op completes.
  function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      T_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      T_MULTU: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      T_DIV:   if (b != 32'd0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      T_DIVU:  if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
      T_MTHI:  m_hi = a;
      T_MTLO:  m_lo = a;
      default: ;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    if (op == T_MULT || op == T_MULTU) return 5;
    if (op == T_DIV || op == T_DIVU) return 10;
    return 0;
  endfunction

  // Check HI/LO/Busy and both MDUOut selections against the model.
  task automatic chk_regs(input string tag);
    chk({tag, ".busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, ".hi"}, HI, m_hi);
    chk({tag, ".lo"}, LO, m_lo);
    MFSel = 1'b0; #1;
    chk({tag, ".out_hi"}, MDUOut, m_hi);
    MFSel = 1'b1; #1;
    chk({tag, ".out_lo"}, MDUOut, m_lo);
  endtask

  // Issue one op at the current negedge and follow it through to completion.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = lat_of(op);
    MDUOp = op; MDUIn1 = a; MDUIn2 = b; Start = 1'b1;
    tick();
    Start = 1'b0; MDUOp = T_NONE;
    for (int i = 0; i < lat; i++) begin
      chk({tag, ".busy_win"}, {31'd0, Busy}, 32'd1);
      chk({tag, ".hold_hi"}, HI, m_hi);
      tick();
    end
    model_op(op, a, b);
    chk_regs(tag);
  endtask

  initial begin
    reset = 1'b0; MDUIn1 = '0; MDUIn2 = '0; MDUOp = T_NONE;
    Start = 1'b0; Cancel = 1'b0; MFSel = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    tick(); tick();
    reset = 1'b1;
    chk_regs("reset");

    // Reset then MULT
    do_op("mult", T_MULT, 32'hFFFFFFFE, 32'd3);
    chk("mult.hi_const", HI, 32'hFFFFFFFF);
    chk("mult.lo_const", LO, 32'hFFFFFFFA);

    // MULTU then back-to-back DIV
    do_op("multu", T_MULTU, 32'hFFFFFFFF, 32'd2);
    chk("multu.hi_const", HI, 32'd1);
    do_op("div_neg", T_DIV, 32'hFFFFFFF9, 32'd2);
    chk("div_neg.lo_const", LO, 32'hFFFFFFFD);
    chk("div_neg.hi_const", HI, 32'hFFFFFFFF);

    // Divide corner cases
    do_op("mthi", T_MTHI, 32'h1234, 32'd0);
    do_op("mtlo", T_MTLO, 32'h5678, 32'd0);
    do_op("divu_zero", T_DIVU, 32'd7, 32'd0);
    chk("divu_zero.hi_const", HI, 32'h1234);
    do_op("div_ovf", T_DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("div_ovf.lo_const", LO, 32'h80000000);
    chk("div_ovf.hi_const", HI, 32'd0);
    do_op("div_zero_s", T_DIV, 32'h80000000, 32'd0);

    // Cancel in busy cycle 3 of a MULT
    MDUOp = T_MULT; MDUIn1 = 32'd1000; MDUIn2 = 32'd1000; Start = 1'b1;
    tick();
    Start = 1'b0; MDUOp = T_NONE;
    chk("cancel.b1", {31'd0, Busy}, 32'd1); tick();
    chk("cancel.b2", {31'd0, Busy}, 32'd1); tick();
    Cancel = 1'b1;
    tick();
    Cancel = 1'b0;
    chk_regs("cancel.after");
    for (int i = 0; i < 6; i++) tick();
    chk_regs("cancel.late");

    // Cancel together with MTLO start
    MDUOp = T_MTLO; MDUIn1 = 32'hDEADBEEF; Start = 1'b1; Cancel = 1'b1;
    tick();
    Start = 1'b0; Cancel = 1'b0; MDUOp = T_NONE;
    chk_regs("cancel_mtlo");

    // Start during busy: MTHI presented mid-window is ignored
    MDUOp = T_DIV; MDUIn1 = 32'd100; MDUIn2 = 32'd7; Start = 1'b1;
    tick();
    Start = 1'b0; MDUOp = T_NONE;
    for (int i = 0; i < 10; i++) begin
      chk("ign.busy", {31'd0, Busy}, 32'd1);
      if (i == 3) begin MDUOp = T_MTHI; MDUIn1 = 32'hAAAA5555; Start = 1'b1; end
      else begin MDUOp = T_NONE; Start = 1'b0; end
      tick();
    end
    Start = 1'b0; MDUOp = T_NONE;
    model_op(T_DIV, 32'd100, 32'd7);
    chk_regs("ign.done");
    chk("ign.hi_const", HI, 32'd2);

    // Cancel on the commit edge discards the result
    MDUOp = T_MULTU; MDUIn1 = 32'd9; MDUIn2 = 32'd9; Start = 1'b1;
    tick();
    Start = 1'b0; MDUOp = T_NONE;
    for (int i = 0; i < 4; i++) tick();
    Cancel = 1'b1;
    tick();
    Cancel = 1'b0;
    chk_regs("cancel_commit");

    // Reset mid-RUN at busy cycle 4 of a DIV
    MDUOp = T_DIV; MDUIn1 = 32'd50; MDUIn2 = 32'd3; Start = 1'b1;
    tick();
    Start = 1'b0; MDUOp = T_NONE;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    chk_regs("rst_mid");
    for (int i = 0; i < 10; i++) tick();
    chk_regs("rst_mid.late");

    // Randomized ops, including zero divisors and the signed overflow case
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      case ($urandom_range(0, 9))
        0, 1: op = T_MULT;
        2:    op = T_MULTU;
        3, 4: op = T_DIV;
        5:    op = T_DIVU;
        6:    op = T_MTHI;
        7:    op = T_MTLO;
        8:    op = T_NONE;
        default: op = 4'hF;
      endcase
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(16, 31);
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 11) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      do_op("rand", op, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller for the P7 MIPS pipeline's EX stage, sitting beside the single-cycle ALU. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations, sequences a fixed-latency busy window for each, commits results to the HI/LO registers, and supplies HI or LO to the datapath for MFHI/MFLO. The hazard unit stalls on `Busy` (or `Start`). The exception logic cancels in-flight operations through `Cancel`.

## Interface
- `MUL_LAT`, 5: busy cycles for MULT/MULTU.
- `DIV_LAT`, 10: busy cycles for DIV/DIVU.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset; one clock, sampled on the rising edge of `clk`.
- `MDUIn1`  in  32  rs operand.
- `MDUIn2`  in  32  rt operand.
- `MDUOp`  in  4  0000 none, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO; others are treated as none.
- `Start`  in  1  qualifies `MDUOp` this cycle.
- `Cancel`  in  1  abort the current or incoming operation (exception/flush).
- `MFSel`  in  1  0 selects HI, 1 selects LO, on `MDUOut`.
- `Busy`  out  1  a multi-cycle operation is in flight.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.
- `MDUOut`  out  32  `MFSel` ? LO : HI, combinational.

## Operation
- **States:** IDLE, RUN. A 4-bit down-counter `cnt` runs alongside.
- **Reset** (`reset`=0 at an edge):
  - state is IDLE, `cnt`=0, HI=0, LO=0, pending registers=0.
  - `Busy`=0 and `MDUOut`=0.
- **IDLE, `Start`=1, `Cancel`=0:**
  - MULT/MULTU/DIV/DIVU:
    - latch the 64-bit result into pending registers `pHI`/`pLO`.
    - load `cnt` with the latency.
    - go to RUN.
  - MTHI: HI←`MDUIn1` at this edge. State stays IDLE and `Busy` stays 0.
  - MTLO: LO←`MDUIn1` at this edge. State stays IDLE and `Busy` stays 0.
  - none/undefined: no effect.
- **RUN:**
  - `cnt` decrements each edge.
  - On the edge where `cnt`=1, HI←`pHI`, LO←`pLO`, and state→IDLE.
  - `Start` is ignored while in RUN. The upstream stall guarantees none is presented; the bench checks that the HI/LO outcome is unaffected.
- **Cancel:**
  - `Cancel`=1 in IDLE blocks any `Start` that same cycle, including MTHI/MTLO.
  - `Cancel`=1 in RUN sends state→IDLE at the next edge with HI/LO unchanged and pending results discarded.
  - `Cancel` on the commit edge (`cnt`=1) also discards; cancel wins.
- **Arithmetic:**
  - MULT: signed 32×32→64; {HI,LO} = product.
  - MULTU: unsigned 32×32→64; {HI,LO} = product.
  - DIV: LO=quotient truncated toward zero; HI=remainder, with the sign of the dividend (`MDUIn1`).
  - DIVU: unsigned; LO=quotient, HI=remainder.
  - Divisor 0: the full `DIV_LAT` busy window still runs, and HI/LO are left unchanged at commit.
  - Signed `32'h80000000 / -1`: LO=`32'h80000000`, HI=0.
- **Reset mid-RUN:** reset wins over all other events. Return to reset state; no commit.

## Timing
- `Start` of MULT at cycle T, with `Busy`=0:
  - `Busy`=1 in cycles T+1 … T+`MUL_LAT`.
  - New HI/LO are visible from cycle T+`MUL_LAT`+1, when `Busy` is 0.
  - `DIV_LAT` applies the same way for DIV/DIVU.
- Back-to-back: a new `Start` is accepted in the first cycle `Busy`=0 after a commit, with no dead cycle.
- MTHI/MTLO: the value is visible on HI/LO and `MDUOut` in cycle T+1.
- `MDUOut` and `Busy` are pure functions of registered state plus `MFSel`. There is no combinational path from `Start` to `Busy`; the hazard unit ORs `Start`-class ops itself.
- Cancel in RUN: `Busy`=0 in the following cycle.

## Structure
- **Shared package `mdu_pkg`:**
  - `MDUOp` encodings.
  - default `MUL_LAT`/`DIV_LAT`.
  - state enum {IDLE, RUN}.
- **Sub-module `mdu_arith`:** a combinational block that computes the 64-bit result for mult/multu/div/divu from the operands and op, and flags divide-by-zero.
- **`mdu_ctrl` proper:** the FSM, counter, pending and HI/LO registers, and the `MFSel` mux.

## Test plan
- **Reset then MULT:**
  - After reset, HI=LO=`MDUOut`=0.
  - MULT `32'hFFFFFFFE`×3 → `Busy` high for 5 cycles, then HI=`FFFFFFFF`, LO=`FFFFFFFA`.
- **MULTU then back-to-back DIV:**
  - MULTU `FFFFFFFF`×2 → HI=1, LO=`FFFFFFFE`.
  - DIV −7/2 starts on the first idle cycle → after 10 busy cycles, LO=`FFFFFFFD`, HI=`FFFFFFFF`.
- **Divide corner cases:**
  - DIVU 7/0 with HI=`1234`, LO=`5678` preloaded via MTHI/MTLO → `Busy` for 10 cycles, HI/LO unchanged.
  - DIV `80000000`/`FFFFFFFF` → LO=`80000000`, HI=0.
- **Cancel:**
  - MULT started, `Cancel` in busy cycle 3 → `Busy`=0 next cycle, HI/LO hold old values.
  - `Cancel` together with a `Start` of MTLO → LO unchanged.
- **Start during busy:** DIV running, MTHI `AAAA5555` presented mid-window → ignored; the final HI equals the DIV remainder.
- **Reset mid-RUN:** `reset`=0 at busy cycle 4 of DIV → the next cycle shows `Busy`=0, HI=LO=0, with no later commit. `MFSel` toggling selects HI/LO on `MDUOut` in the same cycle.
